fetch_unit: RTL and testbench

Instruction fetch stage of the pipelined processor, directly upstream of `decode`. It owns the program counter and issues requests to instruction memory over a variable-latency req/ack handshake. Fetched words go into a 2-entry instruction queue, and the queue head is presented to decode with a valid/ready handshake. Branch/jump redirects from execute flush the queue, and a consumed HALT stops fetching.

---
 rtl/fetch_unit.sv | 216 +++++++++++++++++++++
 tb/tb_fetch_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem requests,
// buffers returned words in a 2-entry queue and presents the head to decode.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [15:0] instruction,
    output logic [15:0] pc_plus2,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        halted,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DROP   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state_r, state_next_s;
    logic [15:0] pc_r, pc_next_s;
    logic        req_r, req_next_s;
    logic [15:0] addr_r, addr_next_s;
    logic [15:0] q0_word_r, q0_word_next_s, q0_pc2_r, q0_pc2_next_s;
    logic [15:0] q1_word_r, q1_word_next_s, q1_pc2_r, q1_pc2_next_s;
    logic [1:0]  count_r, count_next_s;
    logic        valid_r;
    logic        halted_r, halted_next_s;
    logic        err_r, err_next_s;

    logic        ack_s, pending_s, pop_s, redir_s, halt_take_s;
    logic [15:0] target_s, base_pc_s, new_pc2_s;

    // A request is outstanding while req_r is high; pending means it stays so past this edge.
    assign ack_s       = req_r & imem_ack;
    assign pending_s   = req_r & ~imem_ack;
    assign pop_s       = valid_r & inst_ready;
    assign redir_s     = redirect_valid & (state_r != ST_HALTED);
    assign target_s    = {redirect_pc[15:1], 1'b0};
    assign base_pc_s   = redir_s ? target_s : pc_r;
    assign new_pc2_s   = addr_r + 16'd2;
    assign halt_take_s = (state_r == ST_RUN) & pop_s & halt & ~redir_s;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: redirect has priority over halt.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (redir_s && pending_s) begin
                    state_next_s = ST_DROP;
                end else if (redir_s) begin
                    state_next_s = ST_RUN;
                end else if (halt_take_s) begin
                    state_next_s = ST_HALTED;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DROP: begin
                if (ack_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_DROP;
                end
            end
            ST_HALTED: state_next_s = ST_HALTED;
            default:   state_next_s = ST_RUN;
        endcase
    end

    // Datapath next values: PC, request, queue and status flags.
    always_comb begin
        pc_next_s      = pc_r;
        req_next_s     = req_r;
        addr_next_s    = addr_r;
        q0_word_next_s = q0_word_r;
        q0_pc2_next_s  = q0_pc2_r;
        q1_word_next_s = q1_word_r;
        q1_pc2_next_s  = q1_pc2_r;
        count_next_s   = count_r;
        halted_next_s  = halted_r;
        err_next_s     = err_r | (redir_s & redirect_pc[0]);
        case (state_r)
            ST_RUN: begin
                if (redir_s) begin
                    count_next_s = 2'd0;
                    if (pending_s) begin
                        pc_next_s = target_s;
                    end else begin
                        req_next_s  = 1'b1;
                        addr_next_s = target_s;
                        pc_next_s   = target_s + 16'd2;
                    end
                end else if (halt_take_s) begin
                    count_next_s  = 2'd0;
                    halted_next_s = 1'b1;
                    req_next_s    = pending_s;
                end else begin
                    case ({ack_s, pop_s})
                        2'b10: begin
                            count_next_s = count_r + 2'd1;
                            if (count_r == 2'd0) begin
                                q0_word_next_s = imem_rdata;
                                q0_pc2_next_s  = new_pc2_s;
                            end else begin
                                q1_word_next_s = imem_rdata;
                                q1_pc2_next_s  = new_pc2_s;
                            end
                        end
                        2'b01: begin
                            count_next_s   = count_r - 2'd1;
                            q0_word_next_s = q1_word_r;
                            q0_pc2_next_s  = q1_pc2_r;
                        end
                        2'b11: begin
                            if (count_r == 2'd2) begin
                                q0_word_next_s = q1_word_r;
                                q0_pc2_next_s  = q1_pc2_r;
                                q1_word_next_s = imem_rdata;
                                q1_pc2_next_s  = new_pc2_s;
                            end else begin
                                q0_word_next_s = imem_rdata;
                                q0_pc2_next_s  = new_pc2_s;
                            end
                        end
                        default: count_next_s = count_r;
                    endcase
                    // Only request when a returning word is guaranteed a free slot.
                    if (pending_s) begin
                        req_next_s = 1'b1;
                    end else if (count_next_s != 2'd2) begin
                        req_next_s  = 1'b1;
                        addr_next_s = pc_r;
                        pc_next_s   = pc_r + 16'd2;
                    end else begin
                        req_next_s = 1'b0;
                    end
                end
            end
            ST_DROP: begin
                count_next_s = 2'd0;
                if (ack_s) begin
                    req_next_s  = 1'b1;
                    addr_next_s = base_pc_s;
                    pc_next_s   = base_pc_s + 16'd2;
                end else begin
                    pc_next_s = base_pc_s;
                end
            end
            ST_HALTED: begin
                count_next_s = 2'd0;
                req_next_s   = pending_s;
            end
            default: begin
                count_next_s = 2'd0;
                req_next_s   = 1'b0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r      <= RESET_PC;
            req_r     <= 1'b0;
            addr_r    <= RESET_PC;
            q0_word_r <= 16'h0000;
            q0_pc2_r  <= 16'h0000;
            q1_word_r <= 16'h0000;
            q1_pc2_r  <= 16'h0000;
            count_r   <= 2'd0;
            valid_r   <= 1'b0;
            halted_r  <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            pc_r      <= pc_next_s;
            req_r     <= req_next_s;
            addr_r    <= addr_next_s;
            q0_word_r <= q0_word_next_s;
            q0_pc2_r  <= q0_pc2_next_s;
            q1_word_r <= q1_word_next_s;
            q1_pc2_r  <= q1_pc2_next_s;
            count_r   <= count_next_s;
            valid_r   <= (count_next_s != 2'd0);
            halted_r  <= halted_next_s;
            err_r     <= err_next_s;
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = addr_r;
    assign inst_valid  = valid_r;
    assign instruction = q0_word_r;
    assign pc_plus2    = q0_pc2_r;
    assign halted      = halted_r;
    assign err         = err_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory returns addr + 16'h1000 after mem_lat wait cycles.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] instruction;
    logic [15:0] pc_plus2;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        halted;
    logic        err;

    int checks;
    int errors;
    int mem_lat;
    int wait_cnt;
    logic prev_req;
    logic prev_ack;

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .instruction(instruction), .pc_plus2(pc_plus2),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .halted(halted), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one edge, then let the memory decide its ack for the coming cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (imem_req) begin
            if (!prev_req || prev_ack) wait_cnt = 0;
            else wait_cnt = wait_cnt + 1;
            imem_ack   = (wait_cnt >= mem_lat);
            imem_rdata = imem_ack ? (imem_addr + 16'h1000) : 16'h0000;
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 16'h0000;
        end
        prev_req = imem_req;
        prev_ack = imem_ack;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_req"}, imem_req, 1'b0);
        chk16({tag, "_addr"}, imem_addr, 16'h0000);
        chk1({tag, "_valid"}, inst_valid, 1'b0);
        chk16({tag, "_instr"}, instruction, 16'h0000);
        chk16({tag, "_pc2"}, pc_plus2, 16'h0000);
        chk1({tag, "_halted"}, halted, 1'b0);
        chk1({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0000;
        inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0000; halt = 1'b0;
        mem_lat = 0; wait_cnt = 0; prev_req = 1'b0; prev_ack = 1'b0;
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Zero-wait streaming
        tick(); chk1("e1_req", imem_req, 1'b1); chk16("e1_addr", imem_addr, 16'h0000);
        chk1("e1_valid", inst_valid, 1'b0);
        tick(); chk16("e2_addr", imem_addr, 16'h0002); chk1("e2_valid", inst_valid, 1'b1);
        chk16("e2_instr", instruction, 16'h1000); chk16("e2_pc2", pc_plus2, 16'h0002);
        tick(); chk16("e3_addr", imem_addr, 16'h0004);
        chk16("e3_instr", instruction, 16'h1002); chk16("e3_pc2", pc_plus2, 16'h0004);

        // Backpressure, then 3-cycle memory latency
        inst_ready = 1'b0; mem_lat = 3;
        tick(); chk1("e4_req", imem_req, 1'b0); chk16("e4_instr", instruction, 16'h1002);
        inst_ready = 1'b1;
        tick(); chk16("e5_instr", instruction, 16'h1004); chk16("e5_pc2", pc_plus2, 16'h0006);
        chk1("e5_req", imem_req, 1'b1); chk16("e5_addr", imem_addr, 16'h0006);
        inst_ready = 1'b0;
        tick(); tick(); tick();
        chk1("e8_req_held", imem_req, 1'b1);
        tick(); chk1("e9_req", imem_req, 1'b0); chk16("e9_instr", instruction, 16'h1004);
        tick(); chk1("e10_req", imem_req, 1'b0); chk1("e10_valid", inst_valid, 1'b1);
        inst_ready = 1'b1;
        tick(); chk16("e11_instr", instruction, 16'h1006); chk16("e11_pc2", pc_plus2, 16'h0008);
        chk16("e11_addr", imem_addr, 16'h0008);
        tick(); chk1("e12_valid", inst_valid, 1'b0);

        // Redirect to 0040 while the 0008 request is outstanding
        redirect_valid = 1'b1; redirect_pc = 16'h0040;
        tick(); chk1("e13_req", imem_req, 1'b1); chk16("e13_addr", imem_addr, 16'h0008);
        chk1("e13_valid", inst_valid, 1'b0);
        redirect_valid = 1'b0;
        tick(); chk16("e14_addr", imem_addr, 16'h0008); chk1("e14_valid", inst_valid, 1'b0);
        tick(); chk16("e15_addr", imem_addr, 16'h0040); chk1("e15_valid", inst_valid, 1'b0);
        mem_lat = 0;
        tick(); chk1("e16_valid", inst_valid, 1'b0);
        tick(); chk1("e17_valid", inst_valid, 1'b1); chk16("e17_instr", instruction, 16'h1040);
        chk16("e17_pc2", pc_plus2, 16'h0042);

        // Misaligned redirect
        redirect_valid = 1'b1; redirect_pc = 16'h0041;
        tick(); chk1("e18_err", err, 1'b1); chk16("e18_addr", imem_addr, 16'h0040);
        chk1("e18_valid", inst_valid, 1'b0);
        redirect_valid = 1'b0;
        tick(); chk16("e19_instr", instruction, 16'h1040); chk16("e19_pc2", pc_plus2, 16'h0042);
        redirect_valid = 1'b1; redirect_pc = 16'h0080;
        tick(); chk1("e20_err", err, 1'b1); chk16("e20_addr", imem_addr, 16'h0080);
        redirect_valid = 1'b0;
        tick(); chk16("e21_instr", instruction, 16'h1080);

        // Redirect and HALT in the same cycle: redirect wins
        halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0100;
        tick(); chk1("e22_halted", halted, 1'b0); chk16("e22_addr", imem_addr, 16'h0100);
        halt = 1'b0; redirect_valid = 1'b0;
        tick(); chk1("e23_valid", inst_valid, 1'b1); chk16("e23_instr", instruction, 16'h1100);
        mem_lat = 2;
        tick(); chk16("e24_instr", instruction, 16'h1102); chk16("e24_addr", imem_addr, 16'h0104);

        // HALT accepted with a request outstanding
        halt = 1'b1;
        tick(); chk1("e25_halted", halted, 1'b1); chk1("e25_valid", inst_valid, 1'b0);
        chk1("e25_req", imem_req, 1'b1); chk16("e25_addr", imem_addr, 16'h0104);
        halt = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0200;
        tick(); chk1("e26_req", imem_req, 1'b1); chk16("e26_addr", imem_addr, 16'h0104);
        tick(); chk1("e27_req", imem_req, 1'b0); chk1("e27_valid", inst_valid, 1'b0);
        tick(); chk1("e28_req", imem_req, 1'b0); chk16("e28_addr", imem_addr, 16'h0104);
        chk1("e28_halted", halted, 1'b1); chk1("e28_err", err, 1'b1);
        redirect_valid = 1'b0;

        // Reset, then PC wrap through FFFE
        rst = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0000;
        prev_req = 1'b0; prev_ack = 1'b0; mem_lat = 0;
        #1;
        check_reset_outputs("rst2");
        @(negedge clk);
        rst = 1'b1;
        tick(); chk16("w1_addr", imem_addr, 16'h0000);
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        tick(); chk16("w2_addr", imem_addr, 16'hFFFE); chk1("w2_valid", inst_valid, 1'b0);
        redirect_valid = 1'b0;
        tick(); chk16("w3_instr", instruction, 16'h0FFE); chk16("w3_pc2", pc_plus2, 16'h0000);
        chk16("w3_addr", imem_addr, 16'h0000);
        tick(); chk16("w4_instr", instruction, 16'h1000); chk16("w4_pc2", pc_plus2, 16'h0002);
        chk16("w4_addr", imem_addr, 16'h0002);

        // Reset mid-request
        rst = 1'b0;
        #1;
        check_reset_outputs("rst3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
